pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 16-bit 5-stage pipeline. It drives the load-enable and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards and stalls for a configurable number of cycles.
- Freezes the whole pipeline while data memory is busy.
- Squashes younger instructions when a branch resolves taken in MEM.
- Keeps saturating stall/flush statistics counters.

Parameters:
LOAD_STALL, 1, load-use stall cycles (1 = with forwarding, 2 = without); legal range 1..3
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  pipeline clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
id_rs  in  4  source register A of the instruction in ID
id_rt  in  4  source register B of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  instruction in EX is a load
ex_regwrite  in  1  instruction in EX writes a register
ex_dest  in  4  final destination register of the EX instruction (after regdst mux)
mem_access  in  1  instruction in MEM performs memread or memwrite
dmem_ready  in  1  data memory completes this cycle
branch_taken  in  1  branch in MEM resolved taken
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads a NOP
idex_en  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX loads all-zero control (bubble)
exmem_en  out  1  EX/MEM load enable
exmem_bubble  out  1  EX/MEM loads all-zero control
stall_cycles  out  CNT_W  saturating count of stalled cycles (memory or load-use)
flush_count  out  CNT_W  saturating count of taken-branch flushes
state_o  out  1  0 = RUN, 1 = LU_STALL

Behaviour:
- Control outputs are combinational from the registered state/count and the current-cycle inputs.
- Registered: state, lu_cnt (2 bits), stall_cycles, flush_count.
- Reset (rst_n low, asynchronous):
  - state = RUN, lu_cnt = 0, both counters = 0.
  - All *_en outputs = 0; all flush/bubble outputs = 0.
- Default (no event): all *_en = 1; all flush/bubble = 0.
- Hazard terms:
  - mem_stall = mem_access & ~dmem_ready.
  - lu_hit = ex_memread & ex_regwrite & (ex_dest != 0) & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)).
  - Register 0 never causes a hazard.
- Priority: mem_stall > branch_taken > load-use.
- mem_stall, in any state:
  - pc_en = ifid_en = idex_en = exmem_en = 0; no bubbles or flushes.
  - state and lu_cnt hold; stall_cycles += 1.
  - branch_taken and lu_hit are ignored that cycle and re-evaluated once memory is ready.
- branch_taken (no mem_stall):
  - All enables 1; ifid_flush = idex_bubble = exmem_bubble = 1.
  - flush_count += 1; state -> RUN, lu_cnt -> 0.
  - A branch arriving in LU_STALL aborts the stall.
- Load-use stall (in RUN with lu_hit, or in LU_STALL; no branch, no mem_stall):
  - pc_en = ifid_en = 0; idex_en = 1 with idex_bubble = 1; exmem_en = 1.
  - stall_cycles += 1.
- State machine:
  - RUN & lu_hit & LOAD_STALL == 1: stay RUN. The bubble removes the hazard next cycle.
  - RUN & lu_hit & LOAD_STALL > 1: go to LU_STALL, lu_cnt = LOAD_STALL - 1.
  - LU_STALL: lu_cnt -= 1 each non-frozen cycle; return to RUN on the cycle lu_cnt == 1.
  - LU_STALL does not re-check lu_hit; EX holds a bubble.
- Latency: a load-use stall costs exactly LOAD_STALL cycles plus any memory freeze cycles.
- Counters saturate at 2^CNT_W - 1; no wrap.
- mem_stall and branch_taken in the same cycle: freeze wins; the flush occurs on the first ready cycle, while branch_taken is still asserted (MEM frozen).

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum {RUN, LU_STALL}
  - REG_ADDR_W = 4, REG_ZERO = 4'd0
  - CNT_W default
- One sub-module, hazard_detect: the combinational lu_hit comparator. It is reusable by the forwarding unit.

Test Plan:
- Reset: rst_n = 0 mid-stall (LU_STALL, lu_cnt = 1) -> state_o = 0, all enables 0, counters 0 immediately, without waiting for a clock edge.
- Load-use, LOAD_STALL = 1: ex_memread = 1, ex_regwrite = 1, ex_dest = 3, id_rs = 3 -> one cycle of pc_en = ifid_en = 0 with idex_bubble = 1, then all enables 1; stall_cycles = 1.
- LOAD_STALL = 2, same stimulus -> two stall cycles, state_o = 1 on the second; ex_dest = 0 -> no stall.
- id_rt = 5, ex_dest = 5: with id_uses_rt = 0 -> no stall; with id_uses_rt = 1 -> stall.
- Memory wait: mem_access = 1, dmem_ready low for 3 cycles while a load-use is pending -> 3 fully frozen cycles, then the load-use stall; stall_cycles = 4.
- Branch: branch_taken = 1 during LU_STALL -> ifid_flush = idex_bubble = exmem_bubble = 1, state_o = 0 next cycle, flush_count = 1. Same cycle with mem_stall -> freeze only; flush on the ready cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer
// and the hazard comparators.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam int                    REG_ADDR_W = 4;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 4'd0;
    localparam int                    CNT_W_DEF  = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Register 0 never hazards.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_memread,
    input  logic                  ex_regwrite,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  lu_hit
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_dest == id_rs);
    assign rt_match = id_uses_rt & (ex_dest == id_rt);
    assign lu_hit   = ex_memread & ex_regwrite & (ex_dest != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory freeze,
// taken-branch squash, load-use stall and saturating statistics.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_memread,
    input  logic                  ex_regwrite,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  mem_access,
    input  logic                  dmem_ready,
    input  logic                  branch_taken,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_bubble,
    output logic                  exmem_en,
    output logic                  exmem_bubble,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  state_o
);

    localparam logic [1:0] LU_INIT = 2'(LOAD_STALL - 1);

    state_t     state;
    logic [1:0] lu_cnt;
    logic       lu_hit;
    logic       mem_stall;
    logic       lu_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    hazard_detect u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .ex_dest     (ex_dest),
        .lu_hit      (lu_hit)
    );

    assign mem_stall = mem_access & ~dmem_ready;
    // LU_STALL keeps stalling without re-checking: EX already holds a bubble.
    assign lu_stall  = (state == LU_STALL) | lu_hit;
    assign state_o   = (state == LU_STALL);

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        exmem_bubble = 1'b0;
        if (!rst_n) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (lu_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            lu_cnt       <= 2'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (mem_stall) begin
            stall_cycles <= sat_inc(stall_cycles);
        end else if (branch_taken) begin
            state       <= RUN;
            lu_cnt      <= 2'd0;
            flush_count <= sat_inc(flush_count);
        end else if (state == LU_STALL) begin
            stall_cycles <= sat_inc(stall_cycles);
            if (lu_cnt == 2'd1) begin
                state  <= RUN;
                lu_cnt <= 2'd0;
            end else begin
                lu_cnt <= lu_cnt - 2'd1;
            end
        end else if (lu_hit) begin
            stall_cycles <= sat_inc(stall_cycles);
            if (LOAD_STALL > 1) begin
                state  <= LU_STALL;
                lu_cnt <= LU_INIT;
            end
        end
    end

endmodule
